// File: rtl/fft_bfly_stream.sv
// Streaming radix-2 DIF butterfly: one complex pair per cycle, 3-stage pipe.
// Define FFT_BFLY_SAT_EN to clamp outputs and drive the sticky ovf flag.
module fft_bfly_stream #(
  parameter  int N          = 8,
  parameter  int DATA_WIDTH = 16,
  parameter  int TW_WIDTH   = 16,
  parameter  int SCALE      = 0,
  localparam int KW = (N / 2 > 1) ? $clog2(N / 2) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_a,
  input  logic [2*DATA_WIDTH-1:0] in_b,
  input  logic                    inverse,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_a,
  output logic [2*DATA_WIDTH-1:0] out_b,
  output logic [KW-1:0]           out_k,
  output logic                    out_last,
  output logic                    ovf
);

  localparam int HALF = N / 2;
  localparam int DW   = DATA_WIDTH;
  localparam int TW   = TW_WIDTH;
  localparam int SW   = DW + 1;
  localparam int PW   = SW + TW + 1;
  localparam int RW   = DW + 4;

  localparam logic [KW-1:0]        KMAX = KW'(HALF - 1);
  localparam logic [KW-1:0]        KONE = KW'(1);
  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (TW - 2);
  localparam logic signed [RW-1:0] ONE  = RW'(1);

  function automatic logic signed [TW-1:0] tw_val(
    input int k,
    input bit im
  );
    real ang, amp, v;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    amp = 2.0 ** (TW - 1) - 1.0;
    v   = im ? -$sin(ang) * amp : $cos(ang) * amp;
    if (v >= 0.0) tw_val = TW'($rtoi(v + 0.5));
    else          tw_val = TW'(-$rtoi(0.5 - v));
  endfunction

  function automatic logic signed [RW-1:0] fin(
    input logic signed [RW-1:0] x
  );
    if (SCALE != 0) fin = (x + ONE) >>> 1;
    else            fin = x;
  endfunction

  logic signed [TW-1:0] rom_re [HALF];
  logic signed [TW-1:0] rom_im [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_rom
    localparam logic signed [TW-1:0] WR = tw_val(g, 1'b0);
    localparam logic signed [TW-1:0] WI = tw_val(g, 1'b1);
    assign rom_re[g] = WR;
    assign rom_im[g] = WI;
  end

  logic          advance, accept, first, inv_now;
  logic [KW-1:0] k_cnt;
  logic          inv_lat;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign first    = (k_cnt == '0);
  // k==0 takes the live select; the rest of the frame uses the latch
  assign inv_now  = first ? inverse : inv_lat;

  logic                 v1;
  logic [2*DW-1:0]      a1, b1;
  logic [KW-1:0]        k1;
  logic signed [TW-1:0] w1_re, w1_im;

  logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im;
  assign a1_re = a1[DW-1:0];
  assign a1_im = a1[2*DW-1:DW];
  assign b1_re = b1[DW-1:0];
  assign b1_im = b1[2*DW-1:DW];

  logic                 v2;
  logic signed [SW-1:0] s2_re, s2_im, d2_re, d2_im;
  logic [KW-1:0]        k2;
  logic signed [TW-1:0] w2_re, w2_im;

  logic signed [PW-1:0] p_re, p_im;
  logic [2*DW-1:0]      nxt_a, nxt_b;

  always_comb begin
    p_re = PW'(d2_re) * PW'(w2_re) - PW'(d2_im) * PW'(w2_im);
    p_im = PW'(d2_re) * PW'(w2_im) + PW'(d2_im) * PW'(w2_re);
  end

`ifdef FFT_BFLY_SAT_EN
  localparam logic signed [RW-1:0] MAXV =
    {{(RW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  function automatic logic [DW-1:0] sat(
    input logic signed [RW-1:0] x
  );
    if (x > MAXV)      sat = MAXV[DW-1:0];
    else if (x < MINV) sat = MINV[DW-1:0];
    else               sat = x[DW-1:0];
  endfunction

  function automatic logic hit(
    input logic signed [RW-1:0] x
  );
    hit = (x > MAXV) || (x < MINV);
  endfunction

  logic signed [RW-1:0] f_ar, f_ai, f_br, f_bi;
  logic                 clip;

  always_comb begin
    f_ar  = fin(RW'(s2_re));
    f_ai  = fin(RW'(s2_im));
    f_br  = fin(RW'((p_re + RND) >>> (TW - 1)));
    f_bi  = fin(RW'((p_im + RND) >>> (TW - 1)));
    nxt_a = {sat(f_ai), sat(f_ar)};
    nxt_b = {sat(f_bi), sat(f_br)};
    clip  = hit(f_ar) || hit(f_ai) || hit(f_br) || hit(f_bi);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (advance && v2 && clip) ovf <= 1'b1;
  end
`else
  always_comb begin
    nxt_a = {DW'(fin(RW'(s2_im))), DW'(fin(RW'(s2_re)))};
    nxt_b = {DW'(fin(RW'((p_im + RND) >>> (TW - 1)))),
             DW'(fin(RW'((p_re + RND) >>> (TW - 1))))};
  end

  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      k_cnt     <= '0;
      inv_lat   <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_k     <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        k_cnt <= (k_cnt == KMAX) ? '0 : k_cnt + KONE;
        if (first) inv_lat <= inverse;
      end
      if (advance) begin
        v1    <= in_valid;
        a1    <= in_a;
        b1    <= in_b;
        k1    <= k_cnt;
        w1_re <= rom_re[k_cnt];
        w1_im <= inv_now ? -rom_im[k_cnt] : rom_im[k_cnt];

        v2    <= v1;
        s2_re <= SW'(a1_re) + SW'(b1_re);
        s2_im <= SW'(a1_im) + SW'(b1_im);
        d2_re <= SW'(a1_re) - SW'(b1_re);
        d2_im <= SW'(a1_im) - SW'(b1_im);
        k2    <= k1;
        w2_re <= w1_re;
        w2_im <= w1_im;

        out_valid <= v2;
        out_a     <= nxt_a;
        out_b     <= nxt_b;
        out_k     <= k2;
        out_last  <= (k2 == KMAX);
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_stream.sv
// Bench for fft_bfly_stream: directed cases plus random traffic and
// random back-pressure, all checked against an integer reference model.
module tb_fft_bfly_stream;

  localparam int N     = 8;
  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int SCALE = 0;
  localparam int HALF  = N / 2;
  localparam int KW    = 2;
`ifdef FFT_BFLY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, inverse;
  logic          out_valid, out_ready, out_last, ovf;
  logic [31:0]   in_a, in_b, out_a, out_b;
  logic [KW-1:0] out_k;

  always #5 clk = ~clk;

  fft_bfly_stream #(
    .N(N), .DATA_WIDTH(DW), .TW_WIDTH(TW), .SCALE(SCALE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_k(out_k), .out_last(out_last), .ovf(ovf)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    bit          last;
    bit          clip;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   mk;
  bit   minv, movf;

  function automatic logic [31:0] cx(input int re, input int im);
    return {im[15:0], re[15:0]};
  endfunction

  function automatic longint tw(input int k, input bit im);
    real ang, amp, v;
    ang = 2.0 * 3.14159265358979323846 * k / N;
    amp = 2.0 ** (TW - 1) - 1.0;
    v   = im ? -$sin(ang) * amp : $cos(ang) * amp;
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    return -longint'($rtoi(0.5 - v));
  endfunction

  function automatic longint fin(input longint x, inout bit clip);
    longint y;
    y = x;
    if (SCALE != 0) y = (y + 1) >>> 1;
    if (SAT) begin
      if (y > 32767) begin y = 32767; clip = 1'b1; end
      else if (y < -32768) begin y = -32768; clip = 1'b1; end
    end
    return y;
  endfunction

  function automatic res_t model(
    input logic [31:0] a, input logic [31:0] b, input int k, input bit inv
  );
    longint ar, ai, br, bi, wr, wi, dr, di, pr, pi;
    longint oar, oai, obr, obi;
    res_t   r;
    ar = longint'($signed(a[15:0]));
    ai = longint'($signed(a[31:16]));
    br = longint'($signed(b[15:0]));
    bi = longint'($signed(b[31:16]));
    wr = tw(k, 1'b0);
    wi = inv ? -tw(k, 1'b1) : tw(k, 1'b1);
    dr = ar - br;
    di = ai - bi;
    pr = dr * wr - di * wi;
    pi = dr * wi + di * wr;
    r.clip = 1'b0;
    oar = fin(ar + br, r.clip);
    oai = fin(ai + bi, r.clip);
    obr = fin((pr + (longint'(1) << (TW - 2))) >>> (TW - 1), r.clip);
    obi = fin((pi + (longint'(1) << (TW - 2))) >>> (TW - 1), r.clip);
    r.a    = {oai[15:0], oar[15:0]};
    r.b    = {obi[15:0], obr[15:0]};
    r.k    = k;
    r.last = (k == HALF - 1);
    return r;
  endfunction

  bit          held_v;
  logic [31:0] h_a, h_b;
  int          h_k;

  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
      mk     = 0;
      minv   = 1'b0;
      movf   = 1'b0;
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_a", out_a, h_a);
        chk("hold_b", out_b, h_b);
        chk("hold_k", out_k, h_k);
      end
      held_v = 1'b0;
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", in_ready, 0);
        held_v = 1'b1;
        h_a = out_a;
        h_b = out_b;
        h_k = out_k;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_a", out_a, e.a);
          chk("out_b", out_b, e.b);
          chk("out_k", out_k, e.k);
          chk("out_last", out_last, e.last);
          movf = movf | e.clip;
          chk("ovf", ovf, movf);
          obs_q.push_back(e);
          obs_q[obs_q.size() - 1].a = out_a;
          obs_q[obs_q.size() - 1].b = out_b;
          obs_q[obs_q.size() - 1].k = out_k;
          obs_q[obs_q.size() - 1].last = out_last;
        end
      end
      if (in_valid && in_ready) begin
        if (mk == 0) minv = inverse;
        exp_q.push_back(model(in_a, in_b, mk, minv));
        mk = (mk + 1) % HALF;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit inv);
    int t;
    t = 0;
    in_a = a;
    in_b = b;
    inverse = inv;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
  endtask

  bit rand_on;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    inverse = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_k", out_k, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovf0", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send(cx(1000, 0), cx(200, 0), 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("latency", n, 3);
    @(posedge clk);
    #1;
    send(cx(300, -50), cx(-20, 70), 1'b0);
    send(cx(0, 0), cx(100, 0), 1'b0);
    send(cx(5, 5), cx(1, 2), 1'b0);
    drain();
    chk("t1_a", obs_q[0].a, cx(1200, 0));
    chk("t1_b", obs_q[0].b, cx(800, 0));
    chk("t1_k", obs_q[0].k, 0);
    chk("t1_last0", obs_q[0].last, 0);
    chk("k2_fwd_b", obs_q[2].b, cx(0, 100));
    chk("k3_last", obs_q[3].last, 1);

    send(cx(11, 22), cx(3, 4), 1'b1);
    send(cx(-7, 9), cx(40, -2), 1'b0);
    send(cx(0, 0), cx(100, 0), 1'b0);
    send(cx(8, 8), cx(-8, 8), 1'b0);
    send(cx(1, 1), cx(2, 2), 1'b0);
    send(cx(9, 9), cx(3, 3), 1'b1);
    send(cx(0, 0), cx(100, 0), 1'b1);
    send(cx(4, 4), cx(4, 4), 1'b1);
    drain();
    chk("f2_k0", obs_q[4].k, 0);
    chk("k2_inv_b", obs_q[6].b, cx(0, -100));
    chk("f3_k0", obs_q[8].k, 0);
    chk("k2_after_toggle", obs_q[10].b, cx(0, 100));

    fork
      begin
        for (int i = 0; i < 6; i++)
          send($urandom, $urandom, 1'($urandom));
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", obs_q.size(), 18);

    do_reset();
    send(cx(30000, 0), cx(30000, 0), 1'b0);
    drain();
    chk("ovf_a", obs_q[18].a, SAT ? cx(32767, 0) : cx(-5536, 0));
    repeat (3) @(negedge clk);
    chk("ovf_sticky", ovf, SAT ? 1 : 0);
    @(posedge clk);
    #1;

    send(cx(10, 10), cx(20, 20), 1'b0);
    send(cx(30, 30), cx(40, 40), 1'b0);
    do_reset();
    send(cx(123, -45), cx(-67, 89), 1'b0);
    drain();
    chk("post_rst_cnt", obs_q.size(), 20);
    chk("post_rst_k", obs_q[19].k, 0);

    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom, $urandom, 1'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", obs_q.size(), 320);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_bfly_stream.md
Name: fft_bfly_stream

Overview:
- Radix-2 decimation-in-frequency butterfly processing one complex pair (A, B) per cycle, not N/2 pairs in parallel.
- Twiddle ROM built at elaboration; twiddle index from an internal pair counter; forward/inverse select per frame.
- Valid/ready handshake with full back-pressure, configurable output scaling, optional saturation.
- One instance per FFT stage in the streaming FFT datapath.

Parameters:
- N, 8, transform points for this stage; pairs per frame = N/2; power of 2, >= 2.
- DATA_WIDTH, 16, bits per real/imag component, two's complement.
- TW_WIDTH, 16, twiddle component width, signed Q1.(TW_WIDTH-1).
- SCALE, 0, 1 = both outputs divided by 2 with rounding (block-floating stage); 0 = no scaling.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input pair valid
- in_ready  out  1  block accepts pair this cycle
- in_a  in  2*DATA_WIDTH  {imag, real} of A
- in_b  in  2*DATA_WIDTH  {imag, real} of B
- inverse  in  1  conjugate twiddles; sampled on accept when k==0
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts
- out_a  out  2*DATA_WIDTH  {imag, real} of A'
- out_b  out  2*DATA_WIDTH  {imag, real} of B'
- out_k  out  log2(N/2) (min 1)  twiddle index of this pair
- out_last  out  1  pair k == N/2-1
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset: all stage valids 0, out_valid 0, out_a/out_b/out_k/out_last 0, ovf 0, k counter 0, latched inverse 0. Reset mid-frame discards in-flight pairs; next accepted pair has k = 0.
- Math: A' = A + B; B' = (A - B) * W^k with W = exp(-j*2*pi*k/N); inverse = 1 uses conj(W).
- Twiddle ROM: wr = round(cos(2*pi*k/N) * (2^(TW_WIDTH-1)-1)), wi = round(-sin(...)) likewise, k = 0..N/2-1. Constants at elaboration; no runtime trig.
- Widths: sum/difference at DATA_WIDTH+1 bits. Products full width. Complex-multiply result: add 2^(TW_WIDTH-2), arithmetic shift right TW_WIDTH-1 (round half up).
- SCALE=1: both A' and B' results: add 1, arithmetic shift right 1. Then reduce to DATA_WIDTH (see Optional Feature).
- Pipeline: 3 register stages; stage 1 = input capture + twiddle fetch, stage 2 = add/sub, stage 3 = multiply/round/scale/output.
- Stalling: advance = !out_valid || out_ready; all stages move together only when advance = 1; in_ready = advance.
- Latency: 3 cycles, accept to out_valid, without stall. Throughput: 1 pair/cycle.
- Output hold: out_* stable while out_valid && !out_ready.
- Counter: k increments on each accept (in_valid && in_ready), wraps N/2-1 -> 0.
- inverse latching: latched when k == 0 is accepted; held for the whole frame. Changes mid-frame are ignored.
- Order: k travels with the pair to out_k; out_last = (out_k == N/2-1).
- Bubbles: in_valid low inserts a bubble; k does not advance.

Optional Feature:
- Macro: FFT_BFLY_SAT_EN
- Defined: each final component clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Any clamp on an accepted output sets ovf; ovf clears only on rst.
- Undefined: two's-complement truncation (wrap); ovf tied to 0.

Test Plan (N=8, DATA_WIDTH=16, TW_WIDTH=16, SCALE=0, out_ready=1 unless stated):
- k=0: A=(1000,0), B=(200,0) -> 3 cycles later out_a=(1200,0), out_b=(800,0), out_k=0.
- Frame k=0..3 with 3rd pair (k=2) A=(0,0), B=(100,0), inverse=0 -> out_b real 0, imag 100; 4th output out_last=1; next frame restarts out_k=0.
- Same frame with inverse=1 at k=0 -> k=2 output out_b imag = -100. Toggling inverse at k=1 has no effect until next frame.
- Back-pressure: 6 back-to-back inputs, out_ready low 5 cycles after first output -> in_ready low while stalled, out_* held. After release, all 6 outputs in order, none lost or duplicated.
- Overflow: A=B=(30000,0), k=0 -> with FFT_BFLY_SAT_EN out_a real 32767, ovf=1 and stays 1; without, out_a real -5536, ovf=0.
- Reset mid-frame after 2 accepts -> out_valid 0 and ovf 0 the cycle after rst. First pair accepted after reset has out_k=0.
